seq_csel_sub_64: RTL

SEQ_CSEL_SUB_64 -- requirements
Module: seq_csel_sub_64

---
 rtl/seq_csel_sub_64_pkg.sv | 26 ++
 rtl/seq_csel_sub_64_slice.sv | 32 +++
 rtl/seq_csel_sub_64.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_csel_sub_64_pkg.sv
// -----------------------------------------------------------------------------
// seq_csel_sub_64_pkg
// Shared definitions for the sequential carry-select subtractor:
//   WIDTH_DEF / SLICE_DEF : default operand width and bits handled per cycle
//   NSLICE                : number of slices (cycles in RUN) for the defaults
//   state_t               : controller states IDLE, RUN, DONE
//   idx_width()           : width of a slice index for a given slice count
// -----------------------------------------------------------------------------
package seq_csel_sub_64_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int SLICE_DEF = 16;
  localparam int NSLICE    = WIDTH_DEF / SLICE_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_csel_sub_64_slice.sv
// -----------------------------------------------------------------------------
// csel_sub_slice
// One SLICE-wide step of a - b computed as a + ~b + cin, carry-select style:
// both candidate sums (carry-in 0 and 1) are formed in parallel and the
// incoming carry only drives the final mux.
// Ports:
//   a    [SLICE-1:0]  minuend slice
//   b    [SLICE-1:0]  subtrahend slice (inverted internally)
//   cin               carry-in (1 = no borrow into this slice)
//   sum  [SLICE-1:0]  selected slice result
//   cout              selected carry-out (1 = no borrow out of this slice)
// -----------------------------------------------------------------------------
module csel_sub_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] sum0;
  logic [SLICE:0] sum1;

  assign sum0 = {1'b0, a} + {1'b0, ~b};
  assign sum1 = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, 1'b1};

  assign sum  = cin ? sum1[SLICE-1:0] : sum0[SLICE-1:0];
  assign cout = cin ? sum1[SLICE]     : sum0[SLICE];

endmodule

// File: rtl/seq_csel_sub_64.sv
// -----------------------------------------------------------------------------
// seq_csel_sub_64
// Sequential subtractor: diff = a - b - bin (mod 2^WIDTH), one SLICE per cycle
// through a single shared carry-select slice.
//
// Handshake: start is a request sampled on a rising edge only while IDLE;
// the edge that samples start=1 in IDLE captures a, b and bin and nothing
// else on those inputs matters until the next accept. busy is high for the
// NSLICE RUN cycles, done is high for exactly the one DONE cycle, and diff /
// bout are valid from that DONE cycle until the next DONE entry (or reset).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request pulse
//   a, b [WIDTH-1:0]  operands, bin borrow-in
//   busy, done        status (RUN / single-cycle completion)
//   diff [WIDTH-1:0]  registered difference, bout registered borrow-out
//   fsm_state [1:0]   current controller state for observation
// -----------------------------------------------------------------------------
module seq_csel_sub_64
  import seq_csel_sub_64_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       fsm_state
);

  localparam int NS = WIDTH / SLICE;
  localparam int IW = idx_width(NS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_sum;
  logic             sl_cout;

  // Operand muxing: the shared slice always sees the slice selected by idx.
  assign sl_a = a_q[idx*SLICE +: SLICE];
  assign sl_b = b_q[idx*SLICE +: SLICE];

  csel_sub_slice #(.SLICE(SLICE)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // Working register with the current slice merged in; on the last slice
  // this is the complete result and is loaded straight into diff.
  always_comb begin
    work_next = work;
    work_next[idx*SLICE +: SLICE] = sl_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      work  <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            // a - b - bin = a + ~b + ~bin: no borrow-in means carry-in of 1.
            carry <= ~bin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= sl_cout;
          if (idx == LAST_IDX) begin
            diff  <= work_next;
            // Final carry of 1 means the subtraction did not borrow.
            bout  <= ~sl_cout;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule
